// File: rtl/instruction_memory_if.sv
// Fetch-side bus for instruction_memory: PC read port plus program-load write port.
// Optional addr_err signal exists only when IMEM_ADDR_ERR_EN is defined.
interface instruction_memory_if;
  logic [31:0] AddrIn;
  logic [31:0] DOut;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
`ifdef IMEM_ADDR_ERR_EN
  logic        addr_err;

  modport master (output AddrIn, prog_we, prog_addr, prog_data, input DOut, addr_err);
  modport slave  (input AddrIn, prog_we, prog_addr, prog_data, output DOut, addr_err);
`else
  modport master (output AddrIn, prog_we, prog_addr, prog_data, input DOut);
  modport slave  (input AddrIn, prog_we, prog_addr, prog_data, output DOut);
`endif
endinterface

// File: rtl/instruction_memory.sv
// Word-addressed instruction store with 1-cycle registered read and a program-load write port.
// Macro IMEM_ADDR_ERR_EN: out-of-range reads return 0 and raise addr_err instead of wrapping.
module instruction_memory #(
  parameter int DEPTH     = 256,
  parameter     INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               rst,
  instruction_memory_if.slave bus
);
  localparam int          AW      = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [31:0] mem [DEPTH];

  // Power-up contents only; reset never touches the array.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic          wr_en;
  logic [31:0]   dout_d, dout_q;

  // Modulo gives wrap when the error flag is disabled and is the identity for in-range addresses.
  assign rd_idx = AW'(bus.AddrIn % DEPTH_U);
  assign wr_idx = AW'(prog_addr_trunc(bus.prog_addr));
  assign wr_en  = !rst && bus.prog_we && (bus.prog_addr < DEPTH_U);

  function automatic logic [31:0] prog_addr_trunc(input logic [31:0] a);
    return a;
  endfunction

`ifdef IMEM_ADDR_ERR_EN
  logic rd_in_range;
  logic addr_err_d, addr_err_q;

  assign rd_in_range = bus.AddrIn < DEPTH_U;

  always_comb begin
    dout_d     = '0;
    addr_err_d = 1'b0;
    if (!rst) begin
      if (rd_in_range) dout_d = mem[rd_idx];
      else             addr_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    addr_err_q <= addr_err_d;
  end

  assign bus.addr_err = addr_err_q;
`else
  always_comb begin
    dout_d = '0;
    if (!rst) dout_d = mem[rd_idx];
  end
`endif

  always_ff @(posedge clk) begin
    dout_q <= dout_d;
  end

  // Read data is captured from the pre-write contents, giving read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= bus.prog_data;
  end

  assign bus.DOut = dout_q;
endmodule

// File: tb/tb_instruction_memory.sv
// Directed scoreboard bench for instruction_memory (DEPTH=256); covers both IMEM_ADDR_ERR_EN builds.
module tb_instruction_memory;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  instruction_memory_if imem_bus ();

  instruction_memory #(.DEPTH(256), .INIT_FILE("")) dut (
    .clk (clk),
    .rst (rst),
    .bus (imem_bus)
  );

  typedef struct {
    logic [31:0] dout;
    logic        err;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  logic issue = 1'b0;
  logic resp_valid = 1'b0;

  always @(posedge clk) resp_valid <= issue;

  // Monitor: compares each registered response against the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_underflow: response DOut=%h with no expectation", imem_bus.DOut);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        tests++;
        if (imem_bus.DOut !== e.dout) begin
          fails++;
          $display("FAIL %s: DOut got %h expected %h", e.name, imem_bus.DOut, e.dout);
        end else begin
          $display("[TB] %s: DOut=%h ok", e.name, imem_bus.DOut);
        end
`ifdef IMEM_ADDR_ERR_EN
        tests++;
        if (imem_bus.addr_err !== e.err) begin
          fails++;
          $display("FAIL %s_err: addr_err got %b expected %b", e.name, imem_bus.addr_err, e.err);
        end
`endif
      end
    end
  end

  // One clock of stimulus; the response appears after the next rising edge.
  task automatic step(input logic r, input logic [31:0] a, input logic we,
                      input logic [31:0] wa, input logic [31:0] wd,
                      input logic [31:0] ed, input logic ee, input string nm);
    exp_t e;
    @(negedge clk);
    rst                = r;
    imem_bus.AddrIn    = a;
    imem_bus.prog_we   = we;
    imem_bus.prog_addr = wa;
    imem_bus.prog_data = wd;
    e.dout = ed;
    e.err  = ee;
    e.name = nm;
    exp_q.push_back(e);
    issue = 1'b1;
  endtask

`ifdef IMEM_ADDR_ERR_EN
  localparam logic OOR_ERR = 1'b1;
  localparam logic [31:0] OOR_256 = 32'h0000_0000;
  localparam logic [31:0] OOR_300 = 32'h0000_0000;
  localparam logic [31:0] OOR_MAX = 32'h0000_0000;
`else
  localparam logic OOR_ERR = 1'b0;
  localparam logic [31:0] OOR_256 = 32'hDEAD_BEEF;  // wraps to word 0
  localparam logic [31:0] OOR_300 = 32'h0000_0000;  // wraps to word 44, never written
  localparam logic [31:0] OOR_MAX = 32'h0FF0_0FF0;  // wraps to word 255
`endif

  initial begin
    rst                = 1'b1;
    imem_bus.AddrIn    = '0;
    imem_bus.prog_we   = 1'b0;
    imem_bus.prog_addr = '0;
    imem_bus.prog_data = '0;

    // Reset holds output at 0 and blocks writes.
    step(1, 32'd5, 1, 32'd5, 32'hCAFE_F00D, 32'h0, 0, "reset_0");
    step(1, 32'd5, 0, 32'd0, 32'h0,         32'h0, 0, "reset_1");

    // Program load.
    step(0, 32'd5, 1, 32'd0, 32'hDEAD_BEEF, 32'h0, 0, "rd5_after_rst_write");
    step(0, 32'd5, 1, 32'd1, 32'h1234_5678, 32'h0, 0, "rd5_again");
    step(0, 32'd0, 0, 32'd0, 32'h0,         32'hDEAD_BEEF, 0, "read_w0");
    step(0, 32'd1, 0, 32'd0, 32'h0,         32'h1234_5678, 0, "read_w1");

    // Same-word collision is read-before-write.
    step(0, 32'd0, 1, 32'd3, 32'hAAAA_AAAA, 32'hDEAD_BEEF, 0, "read_w0_wr3");
    step(0, 32'd3, 1, 32'd3, 32'h5555_5555, 32'hAAAA_AAAA, 0, "collide_old");
    step(0, 32'd3, 0, 32'd0, 32'h0,         32'h5555_5555, 0, "collide_new");

    // Address glitch between edges: only the value at the edge matters.
    step(0, 32'd0, 0, 32'd0, 32'h0,         32'h1234_5678, 0, "glitch");
    #1 imem_bus.AddrIn = 32'd7;
    #1 imem_bus.AddrIn = 32'd1;

    // Out-of-range writes are dropped with no wrap.
    step(0, 32'd3, 1, 32'd255, 32'h0FF0_0FF0, 32'h5555_5555, 0, "wr255");
    step(0, 32'd3, 1, 32'd300, 32'hFFFF_FFFF, 32'h5555_5555, 0, "wr300");
    step(0, 32'd3, 1, 32'd256, 32'hFFFF_FFFF, 32'h5555_5555, 0, "wr256");
    step(0, 32'd44, 0, 32'd0, 32'h0,        32'h0,         0, "read_w44");
    step(0, 32'd0,  0, 32'd0, 32'h0,        32'hDEAD_BEEF, 0, "read_w0_kept");
    step(0, 32'd255, 0, 32'd0, 32'h0,       32'h0FF0_0FF0, 0, "read_w255");

    // Out-of-range reads.
    step(0, 32'd256,        0, 32'd0, 32'h0, OOR_256, OOR_ERR, "oor_256");
    step(0, 32'd1,          0, 32'd0, 32'h0, 32'h1234_5678, 0, "inrange_clears");
    step(0, 32'd300,        0, 32'd0, 32'h0, OOR_300, OOR_ERR, "oor_300");
    step(0, 32'hFFFF_FFFF,  0, 32'd0, 32'h0, OOR_MAX, OOR_ERR, "oor_max");
    step(1, 32'd256,        0, 32'd0, 32'h0, 32'h0, 0, "rst_clears_err");

    // Reset mid-stream.
    step(0, 32'd0, 0, 32'd0, 32'h0, 32'hDEAD_BEEF, 0, "stream_w0");
    step(0, 32'd1, 0, 32'd0, 32'h0, 32'h1234_5678, 0, "stream_w1");
    step(1, 32'd2, 0, 32'd0, 32'h0, 32'h0,         0, "stream_rst");
    step(0, 32'd3, 0, 32'd0, 32'h0, 32'h5555_5555, 0, "stream_w3");

    @(negedge clk);
    issue = 1'b0;
    imem_bus.prog_we = 1'b0;
    repeat (3) @(negedge clk);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
